// File: rtl/clk_ready_pkg.sv
// -----------------------------------------------------------------------------
// clk_ready_pkg
// Shared definitions for the clock-ready / staged-reset sequencer:
//   - FSM state encodings (also exposed on the state readback port)
//   - legal parameter ranges and a helper that validates a configuration
// -----------------------------------------------------------------------------
package clk_ready_pkg;

  // FSM state encodings; the values are visible to software via readback.
  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_FILTER    = 3'd1;
  localparam logic [2:0] ST_HOLDOFF   = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  // Legal parameter ranges.
  localparam int LOCKS_MIN     = 1;
  localparam int LOCKS_MAX     = 8;
  localparam int FILT_LEN_MIN  = 1;
  localparam int FILT_LEN_MAX  = 255;
  localparam int HOLDOFF_W_MIN = 1;
  localparam int STAGES_MIN    = 1;
  localparam int STAGES_MAX    = 8;
  localparam int STAGE_GAP_MIN = 1;

  // True when every parameter lies within its legal range.
  function automatic bit cfg_ok(input int num_locks, input int filt_len,
                                input int holdoff_w, input int num_stages,
                                input int stage_gap);
    return (num_locks  >= LOCKS_MIN)    && (num_locks  <= LOCKS_MAX)    &&
           (filt_len   >= FILT_LEN_MIN) && (filt_len   <= FILT_LEN_MAX) &&
           (holdoff_w  >= HOLDOFF_W_MIN)                                &&
           (num_stages >= STAGES_MIN)   && (num_stages <= STAGES_MAX)   &&
           (stage_gap  >= STAGE_GAP_MIN);
  endfunction

endpackage

// File: rtl/lock_sync_2ff.sv
// -----------------------------------------------------------------------------
// lock_sync_2ff
// Two-flop synchroniser for one asynchronous lock indicator.
// Ports:
//   bus_clk   - destination clock
//   bus_rst_n - asynchronous active-low reset (clears both flops)
//   async_in  - lock indicator from another clock domain
//   sync_out  - synchronised copy, two bus_clk cycles of latency
// -----------------------------------------------------------------------------
module lock_sync_2ff (
  input  logic bus_clk,
  input  logic bus_rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/clk_ready_sequencer.sv
// -----------------------------------------------------------------------------
// clk_ready_sequencer
// Waits for all participating PLL/MMCM locks, filters them, holds off for a
// fixed time, then releases a chain of staged resets one by one and finally
// flags clocks_ready. Any lock loss or soft_reset re-asserts every stage.
// Ports:
//   bus_clk, bus_rst_n - clock and asynchronous active-low reset
//   lock_in            - raw lock indicators (asynchronous)
//   lock_mask          - 1 = lock input participates
//   soft_reset         - synchronous restart request
//   fault_clr          - clears sticky lock_lost bits
//   rst_out            - active-high staged resets, bit 0 released first
//   clocks_ready       - high only in RUN
//   lock_lost          - sticky per-input lock-loss flags
//   state              - FSM state readback
// -----------------------------------------------------------------------------
module clk_ready_sequencer
  import clk_ready_pkg::*;
#(
  parameter int NUM_LOCKS  = 2,
  parameter int FILT_LEN   = 4,
  parameter int HOLDOFF_W  = 16,
  parameter int NUM_STAGES = 3,
  parameter int STAGE_GAP  = 256
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic [NUM_LOCKS-1:0]  lock_in,
  input  logic [NUM_LOCKS-1:0]  lock_mask,
  input  logic                  soft_reset,
  input  logic                  fault_clr,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  clocks_ready,
  output logic [NUM_LOCKS-1:0]  lock_lost,
  output logic [2:0]            state
);

  generate
    if (!cfg_ok(NUM_LOCKS, FILT_LEN, HOLDOFF_W, NUM_STAGES, STAGE_GAP)) begin : g_bad_cfg
      $error("clk_ready_sequencer: parameter out of range");
    end
  endgenerate

  // Counter widths hold the largest value reached, so nothing wraps.
  localparam int FILT_W = $clog2(FILT_LEN + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  logic [NUM_LOCKS-1:0] lock_sync;
  logic                 all_locked;
  logic                 lock_drop;

  logic [2:0]            state_reg,        state_next;
  logic [FILT_W-1:0]     filt_cnt_reg,     filt_cnt_next;
  logic [HOLDOFF_W-1:0]  hold_cnt_reg,     hold_cnt_next;
  logic [GAP_W-1:0]      gap_cnt_reg,      gap_cnt_next;
  logic [NUM_STAGES-1:0] rst_out_reg,      rst_out_next;
  logic                  clocks_ready_reg, clocks_ready_next;
  logic [NUM_LOCKS-1:0]  lock_lost_reg,    lock_lost_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LOCKS; gi++) begin : g_sync
      lock_sync_2ff u_sync (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .async_in  (lock_in[gi]),
        .sync_out  (lock_sync[gi])
      );
    end
  endgenerate

  // Unmasked inputs count as locked, so an all-zero mask is always locked.
  assign all_locked = &(lock_sync | ~lock_mask);

  always_comb begin
    state_next        = state_reg;
    filt_cnt_next     = filt_cnt_reg;
    hold_cnt_next     = hold_cnt_reg;
    gap_cnt_next      = gap_cnt_reg;
    rst_out_next      = rst_out_reg;
    clocks_ready_next = clocks_ready_reg;
    lock_drop         = 1'b0;

    case (state_reg)
      ST_WAIT_LOCK: begin
        rst_out_next      = '1;
        clocks_ready_next = 1'b0;
        if (all_locked) begin
          state_next    = ST_FILTER;
          filt_cnt_next = '0;
        end
      end
      ST_FILTER: begin
        if (!all_locked) begin
          state_next    = ST_WAIT_LOCK;
          filt_cnt_next = '0;
        end else if (filt_cnt_reg == FILT_LAST) begin
          state_next    = ST_HOLDOFF;
          filt_cnt_next = '0;
          hold_cnt_next = '0;
        end else begin
          filt_cnt_next = filt_cnt_reg + FILT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (!all_locked) begin
          lock_drop = 1'b1;
        end else if (&hold_cnt_reg) begin
          // Stage 0 is released on the very edge that enters RELEASE.
          state_next   = ST_RELEASE;
          rst_out_next = rst_out_reg << 1;
          gap_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLDOFF_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!all_locked) begin
          lock_drop = 1'b1;
        end else if (rst_out_reg == '0) begin
          state_next        = ST_RUN;
          clocks_ready_next = 1'b1;
        end else if (gap_cnt_reg == GAP_LAST) begin
          // Shifting in zeros from the bottom releases stages strictly in
          // order and can never re-assert a stage already released.
          rst_out_next = rst_out_reg << 1;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      ST_RUN: begin
        if (!all_locked) begin
          lock_drop = 1'b1;
        end
      end
      default: begin
        state_next = ST_WAIT_LOCK;
      end
    endcase

    if (lock_drop || soft_reset) begin
      state_next        = ST_WAIT_LOCK;
      rst_out_next      = '1;
      clocks_ready_next = 1'b0;
      filt_cnt_next     = '0;
      hold_cnt_next     = '0;
      gap_cnt_next      = '0;
    end

    // A loss seen in the same cycle as fault_clr keeps its bit set.
    lock_lost_next = (fault_clr ? '0 : lock_lost_reg) |
                     (lock_mask & ~lock_sync & {NUM_LOCKS{lock_drop}});
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_reg        <= ST_WAIT_LOCK;
      filt_cnt_reg     <= '0;
      hold_cnt_reg     <= '0;
      gap_cnt_reg      <= '0;
      rst_out_reg      <= '1;
      clocks_ready_reg <= 1'b0;
      lock_lost_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      filt_cnt_reg     <= filt_cnt_next;
      hold_cnt_reg     <= hold_cnt_next;
      gap_cnt_reg      <= gap_cnt_next;
      rst_out_reg      <= rst_out_next;
      clocks_ready_reg <= clocks_ready_next;
      lock_lost_reg    <= lock_lost_next;
    end
  end

  assign rst_out      = rst_out_reg;
  assign clocks_ready = clocks_ready_reg;
  assign lock_lost    = lock_lost_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_clk_ready_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_ready_sequencer
// Scoreboard bench: stimulus pushes the expected output vector
// {state, rst_out, clocks_ready, lock_lost} and the bus_clk cycle at which it
// must appear; a monitor pops an entry whenever the DUT output vector changes.
// Cycle 0 of each scenario is the first rising edge after the stimulus change.
// -----------------------------------------------------------------------------
module tb_clk_ready_sequencer;

  localparam int NUM_LOCKS  = 2;
  localparam int FILT_LEN   = 4;
  localparam int HOLDOFF_W  = 4;
  localparam int NUM_STAGES = 3;
  localparam int STAGE_GAP  = 8;

  logic                  bus_clk    = 1'b0;
  logic                  bus_rst_n  = 1'b0;
  logic [NUM_LOCKS-1:0]  lock_in    = '0;
  logic [NUM_LOCKS-1:0]  lock_mask  = 2'b11;
  logic                  soft_reset = 1'b0;
  logic                  fault_clr  = 1'b0;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  clocks_ready;
  logic [NUM_LOCKS-1:0]  lock_lost;
  logic [2:0]            state;

  clk_ready_sequencer #(
    .NUM_LOCKS  (NUM_LOCKS),
    .FILT_LEN   (FILT_LEN),
    .HOLDOFF_W  (HOLDOFF_W),
    .NUM_STAGES (NUM_STAGES),
    .STAGE_GAP  (STAGE_GAP)
  ) dut (
    .bus_clk      (bus_clk),
    .bus_rst_n    (bus_rst_n),
    .lock_in      (lock_in),
    .lock_mask    (lock_mask),
    .soft_reset   (soft_reset),
    .fault_clr    (fault_clr),
    .rst_out      (rst_out),
    .clocks_ready (clocks_ready),
    .lock_lost    (lock_lost),
    .state        (state)
  );

  always #5 bus_clk = ~bus_clk;

  int cyc = 0;
  always @(posedge bus_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;   // -1 = any cycle
    logic [8:0] vec;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   base  = 0;

  wire [8:0] dut_vec = {state, rst_out, clocks_ready, lock_lost};

  function automatic logic [8:0] pk(input logic [2:0] st, input logic [2:0] ro,
                                    input logic cr, input logic [1:0] ll);
    return {st, ro, cr, ll};
  endfunction

  task automatic push_exp(input int off, input string tag, input logic [2:0] st,
                          input logic [2:0] ro, input logic cr, input logic [1:0] ll);
    exp_t e;
    e.cyc = base + off;
    e.vec = pk(st, ro, cr, ll);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Leaves the caller at the falling edge just before rising edge e.
  task automatic before_edge(input int e);
    while (cyc < e - 1) @(negedge bus_clk);
  endtask

  task automatic start_here();
    @(negedge bus_clk);
    base = cyc + 1;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, req);
    end else begin
      $display("check %s cyc=%0d value=%b ok", name, cyc, got);
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge bus_clk);
    @(negedge bus_clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout cyc=%0d got=%0d pending required=0 pending", name, cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every change of the output vector is one transaction.
  initial begin
    logic [8:0] prev;
    bit         first;
    exp_t       e;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge bus_clk);
      if (first || dut_vec !== prev) begin
        first = 1'b0;
        prev  = dut_vec;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, dut_vec);
        end else begin
          e = exp_q.pop_front();
          if (e.vec !== dut_vec || (e.cyc >= 0 && e.cyc != cyc)) begin
            n_bad++;
            $display("FAIL %s got=%b@cyc%0d required=%b@cyc%0d", e.tag, dut_vec, cyc, e.vec, e.cyc);
          end else begin
            $display("txn %s cyc=%0d vec=%b ok", e.tag, cyc, dut_vec);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=still running required=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    r.cyc = -1;
    r.vec = pk(3'd0, 3'b111, 1'b0, 2'b00);
    r.tag = "reset_state";
    exp_q.push_back(r);
    repeat (3) @(negedge bus_clk);
    check("reset_direct", dut_vec, pk(3'd0, 3'b111, 1'b0, 2'b00));
    bus_rst_n = 1'b1;

    // Nominal sequence, both locks participating.
    start_here();
    lock_in = 2'b11;
    push_exp(2,  "nom_filter",  3'd1, 3'b111, 1'b0, 2'b00);
    push_exp(6,  "nom_holdoff", 3'd2, 3'b111, 1'b0, 2'b00);
    push_exp(22, "nom_stage0",  3'd3, 3'b110, 1'b0, 2'b00);
    push_exp(30, "nom_stage1",  3'd3, 3'b100, 1'b0, 2'b00);
    push_exp(38, "nom_stage2",  3'd3, 3'b000, 1'b0, 2'b00);
    push_exp(39, "nom_run",     3'd4, 3'b000, 1'b1, 2'b00);
    drain("nominal", 80);

    // Loss of lock 0 in RUN.
    start_here();
    lock_in = 2'b10;
    push_exp(2, "run_loss", 3'd0, 3'b111, 1'b0, 2'b01);
    before_edge(base + 4);
    check("run_loss_plus3", dut_vec, pk(3'd0, 3'b111, 1'b0, 2'b01));
    drain("run_loss", 20);

    // fault_clr alone clears the sticky bit.
    start_here();
    fault_clr = 1'b1;
    push_exp(0, "fault_clr", 3'd0, 3'b111, 1'b0, 2'b00);
    @(negedge bus_clk);
    fault_clr = 1'b0;
    drain("fault_clr", 10);

    // One-cycle glitch on lock 1 during FILTER restarts the filter.
    start_here();
    lock_in = 2'b11;
    push_exp(2,  "gl_filter",   3'd1, 3'b111, 1'b0, 2'b00);
    push_exp(5,  "gl_drop",     3'd0, 3'b111, 1'b0, 2'b00);
    push_exp(6,  "gl_refilter", 3'd1, 3'b111, 1'b0, 2'b00);
    push_exp(10, "gl_holdoff",  3'd2, 3'b111, 1'b0, 2'b00);
    push_exp(26, "gl_stage0",   3'd3, 3'b110, 1'b0, 2'b00);
    push_exp(34, "gl_stage1",   3'd3, 3'b100, 1'b0, 2'b00);
    push_exp(42, "gl_stage2",   3'd3, 3'b000, 1'b0, 2'b00);
    push_exp(43, "gl_run",      3'd4, 3'b000, 1'b1, 2'b00);
    before_edge(base + 3);
    lock_in[1] = 1'b0;
    before_edge(base + 4);
    lock_in[1] = 1'b1;
    drain("glitch", 100);

    // Loss on lock 1 in the same cycle as fault_clr: the loss wins.
    start_here();
    lock_in = 2'b01;
    push_exp(2, "loss_vs_clr", 3'd0, 3'b111, 1'b0, 2'b10);
    before_edge(base + 2);
    fault_clr = 1'b1;
    before_edge(base + 3);
    fault_clr = 1'b0;
    drain("loss_vs_clr", 20);

    // soft_reset in RELEASE, then async reset in the second RELEASE.
    start_here();
    lock_in = 2'b11;
    push_exp(2,  "sr_filter",    3'd1, 3'b111, 1'b0, 2'b10);
    push_exp(6,  "sr_holdoff",   3'd2, 3'b111, 1'b0, 2'b10);
    push_exp(22, "sr_stage0",    3'd3, 3'b110, 1'b0, 2'b10);
    push_exp(25, "sr_soft",      3'd0, 3'b111, 1'b0, 2'b10);
    push_exp(26, "sr_filter2",   3'd1, 3'b111, 1'b0, 2'b10);
    push_exp(30, "sr_holdoff2",  3'd2, 3'b111, 1'b0, 2'b10);
    push_exp(46, "sr_stage0_2",  3'd3, 3'b110, 1'b0, 2'b10);
    before_edge(base + 25);
    soft_reset = 1'b1;
    before_edge(base + 26);
    soft_reset = 1'b0;
    before_edge(base + 50);
    @(posedge bus_clk);
    #2;
    push_exp(50, "async_rst", 3'd0, 3'b111, 1'b0, 2'b00);
    bus_rst_n = 1'b0;
    #1;
    check("arst_state",   9'(state),        9'd0);
    check("arst_rst_out", 9'(rst_out),      9'b111);
    check("arst_ready",   9'(clocks_ready), 9'd0);
    check("arst_lost",    9'(lock_lost),    9'd0);
    lock_mask = 2'b01;
    lock_in   = 2'b01;
    drain("async_rst", 5);

    // Mask: lock 1 excluded and held low; same timing as nominal.
    start_here();
    bus_rst_n = 1'b1;
    push_exp(2,  "mask_filter",  3'd1, 3'b111, 1'b0, 2'b00);
    push_exp(6,  "mask_holdoff", 3'd2, 3'b111, 1'b0, 2'b00);
    push_exp(22, "mask_stage0",  3'd3, 3'b110, 1'b0, 2'b00);
    push_exp(30, "mask_stage1",  3'd3, 3'b100, 1'b0, 2'b00);
    push_exp(38, "mask_stage2",  3'd3, 3'b000, 1'b0, 2'b00);
    push_exp(39, "mask_run",     3'd4, 3'b000, 1'b1, 2'b00);
    drain("mask", 80);

    // Loss with lock 1 unmasked-low: only the masked bit is flagged.
    start_here();
    lock_in = 2'b00;
    push_exp(2, "masked_loss", 3'd0, 3'b111, 1'b0, 2'b01);
    drain("masked_loss", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_ready_sequencer.md
CLK_READY_SEQUENCER -- requirements
Module: clk_ready_sequencer

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 2: number of lock inputs (1..8).
REQ-002 SHALL have parameter FILT_LEN, default 4: consecutive all-locked cycles required before acceptance (1..255).
REQ-003 SHALL have parameter HOLDOFF_W, default 16: holdoff counter width; holdoff lasts 2^HOLDOFF_W cycles.
REQ-004 SHALL have parameter NUM_STAGES, default 3: number of staged reset outputs (1..8).
REQ-005 SHALL have parameter STAGE_GAP, default 256: cycles between consecutive stage releases (>=1).
REQ-006 bus_clk  in  1  sole clock; all logic on the rising edge.
REQ-007 bus_rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-008 lock_in  in  NUM_LOCKS  PLL/MMCM lock indicators, asynchronous to bus_clk.
REQ-009 lock_mask  in  NUM_LOCKS  1 = input participates; quasi-static.
REQ-010 soft_reset  in  1  synchronous request to restart sequencing.
REQ-011 fault_clr  in  1  synchronous pulse clearing sticky lock_lost bits.
REQ-012 rst_out  out  NUM_STAGES  active-high staged resets; bit 0 released first.
REQ-013 clocks_ready  out  1  high only in RUN.
REQ-014 lock_lost  out  NUM_LOCKS  sticky: masked input lost lock after acceptance.
REQ-015 state  out  3  current FSM state encoding, for readback.

Function
REQ-016 Each lock_in bit SHALL pass through a 2-flop synchroniser; all decisions use synchronised values.
REQ-017 all_locked SHALL equal AND over i of (lock_sync[i] | ~lock_mask[i]); lock_mask all-zero means always locked.
REQ-018 FSM states SHALL be WAIT_LOCK=0, FILTER=1, HOLDOFF=2, RELEASE=3, RUN=4.
REQ-019 WAIT_LOCK: all rst_out high; enter FILTER when all_locked.
REQ-020 FILTER: count all_locked cycles; enter HOLDOFF after FILT_LEN consecutive; any drop returns to WAIT_LOCK with count cleared.
REQ-021 HOLDOFF: counter runs from 0 to all-ones (2^HOLDOFF_W cycles), then enters RELEASE.
REQ-022 RELEASE: rst_out[0] SHALL deassert in the first RELEASE cycle; rst_out[k] SHALL deassert exactly k*STAGE_GAP cycles later; after the last stage is released the FSM enters RUN on the next cycle.
REQ-023 clocks_ready SHALL be registered and high only while state==RUN.
REQ-024 Loss of all_locked in HOLDOFF, RELEASE or RUN SHALL, on the next cycle, set all rst_out, drop clocks_ready, clear counters, enter WAIT_LOCK, and set lock_lost[i] for each masked input whose lock_sync is low.
REQ-025 soft_reset in any state SHALL behave as in REQ-024 but SHALL NOT set lock_lost.
REQ-026 fault_clr SHALL clear lock_lost; a loss detected in the same cycle SHALL win (bit remains set).
REQ-027 Released stages SHALL never re-assert individually; re-assertion is always all stages together.
REQ-028 Stage counter SHALL be wide enough for STAGE_GAP and SHALL not wrap within RELEASE.

Reset
REQ-029 While bus_rst_n low: rst_out all ones, clocks_ready 0, lock_lost 0, state WAIT_LOCK, synchronisers and counters 0.
REQ-030 Reset deassertion SHALL need no external synchronisation; the first sequencing step follows the synchroniser latency.

Structure
REQ-031 State encodings and parameter-range limits SHALL live in a shared package clk_ready_pkg.
REQ-032 The per-bit synchroniser SHALL be a single sub-module, lock_sync_2ff, instantiated NUM_LOCKS times.

Verification (NUM_LOCKS=2, FILT_LEN=4, HOLDOFF_W=4, NUM_STAGES=3, STAGE_GAP=8; cycle 0 = both lock_in rise)
REQ-033 Nominal: mask=2'b11 -> HOLDOFF at cycle 6, rst_out[0] low at 22, rst_out[1] low at 30, rst_out[2] low at 38, clocks_ready high at 39.
REQ-034 Glitch: lock_in[1] low for 1 cycle during FILTER -> WAIT_LOCK, filter restarts, rst_out stays 3'b111, lock_lost stays 0.
REQ-035 Loss in RUN: lock_in[0] falls -> 3 cycles later rst_out=3'b111, clocks_ready=0, lock_lost=2'b01, state=0.
REQ-036 Mask: mask=2'b01, lock_in[1] held low -> identical timing to REQ-033.
REQ-037 Simultaneous fault_clr and new loss on lock_in[1] -> lock_lost=2'b10; soft_reset in RELEASE -> all rst_out high next cycle, lock_lost unchanged.
REQ-038 Async reset asserted mid-RELEASE -> outputs at REQ-029 values immediately, without waiting for a bus_clk edge.
